// File: rtl/cross_bar_pkg.sv
// Shared topology constants, types and the target-slave decode for the crossbar.
// Imported by the mux controller and its round-robin arbiter.
package cross_bar_pkg;

  localparam int MASTER_N = 4;
  localparam int SLAVE_N  = 4;
  localparam int MASTER_W = 2;
  localparam int SLAVE_W  = 2;
  localparam int ADDR_W   = 32;
  localparam int NONE     = 0;

  // One extra bit so that 0 can mean "none" and 1..N name a port.
  typedef logic [MASTER_W:0] master_num_t;
  typedef logic [SLAVE_W:0]  slave_num_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } slot_st_e;

  // 1-based slave number addressed by the top SLAVE_W address bits.
  function automatic slave_num_t tgt_slave(addr_t a);
    return slave_num_t'({1'b0, a[ADDR_W-1 -: SLAVE_W]})
         + slave_num_t'(1);
  endfunction

endpackage

// File: rtl/cross_bar_rr_arb.sv
// Combinational round-robin pick: first requester after ptr_i, wrapping.
// Ports: req_i (request vector), ptr_i (last winner, 1-based), valid_o, win_o (1-based).
module cross_bar_rr_arb
  import cross_bar_pkg::*;
(
  input  logic [MASTER_N-1:0] req_i,
  input  master_num_t         ptr_i,
  output logic                valid_o,
  output master_num_t         win_o
);

  logic found;
  int   idx;

  always_comb begin
    found = 1'b0;
    idx   = 0;
    win_o = master_num_t'(NONE);
    for (int k = 1; k <= MASTER_N; k++) begin
      idx = (int'(ptr_i) + k - 1) % MASTER_N;
      if (!found && req_i[idx]) begin
        found = 1'b1;
        win_o = master_num_t'(idx + 1);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/cross_bar_mux_ctrl.sv
// Per-slave round-robin arbitration and grant lock driving the crossbar selects.
// Ports: clk, aresetn (sync, low), master_req/addr/ack in; slave_mux, master_mux,
// timeout_err out. Macro CROSS_BAR_MUX_CTRL_TIMEOUT_EN enables forced release.
module cross_bar_mux_ctrl
  import cross_bar_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                         clk,
  input  logic                         aresetn,
  input  logic        [MASTER_N-1:0]   master_req,
  input  addr_t       [MASTER_N-1:0]   master_addr,
  input  logic        [MASTER_N-1:0]   master_ack,
  output master_num_t [SLAVE_N:1]      slave_mux,
  output slave_num_t  [MASTER_N:1]     master_mux,
  output logic        [SLAVE_N-1:0]    timeout_err
);

  slot_st_e            st_q  [SLAVE_N];
  slot_st_e            st_d  [SLAVE_N];
  master_num_t         own_q [SLAVE_N];
  master_num_t         own_d [SLAVE_N];
  master_num_t         ptr_q [SLAVE_N];
  master_num_t         ptr_d [SLAVE_N];
  logic [MASTER_N-1:0] cand  [SLAVE_N];
  logic                arb_v [SLAVE_N];
  master_num_t         arb_w [SLAVE_N];
  logic [MASTER_N-1:0] m_busy;

  function automatic logic [MASTER_N-1:0] onehot(master_num_t o);
    logic [MASTER_N-1:0] r;
    r = '0;
    for (int m = 0; m < MASTER_N; m++)
      if (o == master_num_t'(m + 1)) r[m] = 1'b1;
    return r;
  endfunction

`ifdef CROSS_BAR_MUX_CTRL_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0]       cnt_q [SLAVE_N];
  logic [CW-1:0]       cnt_d [SLAVE_N];
  logic [MASTER_N-1:0] blk_q [SLAVE_N];
  logic [MASTER_N-1:0] blk_d [SLAVE_N];
  logic [SLAVE_N-1:0]  ackd_q, ackd_d;
  logic [SLAVE_N-1:0]  err_q, err_d;
  logic                unused_in;

  assign unused_in   = ^master_addr;
  assign timeout_err = err_q;
`else
  logic unused_in;

  assign unused_in   = ^{master_addr, master_ack}
                     ^ (TIMEOUT_CYC == 0);
  assign timeout_err = '0;
`endif

  // A master already holding any slave is not eligible elsewhere.
  always_comb begin
    for (int m = 0; m < MASTER_N; m++)
      m_busy[m] = (master_mux[m+1] != slave_num_t'(NONE));
  end

  always_comb begin
    for (int s = 0; s < SLAVE_N; s++) begin
      for (int m = 0; m < MASTER_N; m++) begin
        cand[s][m] = master_req[m] && !m_busy[m]
          && (tgt_slave(master_addr[m]) == slave_num_t'(s + 1));
`ifdef CROSS_BAR_MUX_CTRL_TIMEOUT_EN
        cand[s][m] = cand[s][m] && !blk_q[s][m];
`endif
      end
    end
  end

  for (genvar s = 0; s < SLAVE_N; s++) begin : g_arb
    cross_bar_rr_arb u_arb (
      .req_i   (cand[s]),
      .ptr_i   (ptr_q[s]),
      .valid_o (arb_v[s]),
      .win_o   (arb_w[s])
    );
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      for (int s = 0; s < SLAVE_N; s++) begin
        st_q[s]  <= IDLE;
        own_q[s] <= master_num_t'(NONE);
        ptr_q[s] <= master_num_t'(MASTER_N);
`ifdef CROSS_BAR_MUX_CTRL_TIMEOUT_EN
        cnt_q[s] <= '0;
        blk_q[s] <= '0;
`endif
      end
`ifdef CROSS_BAR_MUX_CTRL_TIMEOUT_EN
      ackd_q <= '0;
      err_q  <= '0;
`endif
    end else begin
      st_q  <= st_d;
      own_q <= own_d;
      ptr_q <= ptr_d;
`ifdef CROSS_BAR_MUX_CTRL_TIMEOUT_EN
      cnt_q  <= cnt_d;
      blk_q  <= blk_d;
      ackd_q <= ackd_d;
      err_q  <= err_d;
`endif
    end
  end

  always_comb begin
    st_d  = st_q;
    own_d = own_q;
    ptr_d = ptr_q;
`ifdef CROSS_BAR_MUX_CTRL_TIMEOUT_EN
    cnt_d  = cnt_q;
    ackd_d = ackd_q;
    err_d  = '0;
    // A timed-out owner stays blocked only until it lets go of req.
    for (int s = 0; s < SLAVE_N; s++)
      blk_d[s] = blk_q[s] & master_req;
`endif
    for (int s = 0; s < SLAVE_N; s++) begin
      unique case (st_q[s])
        IDLE: begin
          if (arb_v[s]) begin
            st_d[s]  = BUSY;
            own_d[s] = arb_w[s];
            ptr_d[s] = arb_w[s];
`ifdef CROSS_BAR_MUX_CTRL_TIMEOUT_EN
            cnt_d[s]  = '0;
            ackd_d[s] = 1'b0;
`endif
          end
        end
        BUSY: begin
          if (~|(master_req & onehot(own_q[s]))) begin
            st_d[s]  = IDLE;
            own_d[s] = master_num_t'(NONE);
          end
`ifdef CROSS_BAR_MUX_CTRL_TIMEOUT_EN
          else if (|(master_ack & onehot(own_q[s]))) begin
            ackd_d[s] = 1'b1;
          end else if (!ackd_q[s]) begin
            if (cnt_q[s] == CW'(TIMEOUT_CYC - 1)) begin
              st_d[s]  = IDLE;
              own_d[s] = master_num_t'(NONE);
              err_d[s] = 1'b1;
              blk_d[s] = blk_d[s] | onehot(own_q[s]);
            end else begin
              cnt_d[s] = cnt_q[s] + CW'(1);
            end
          end
`endif
        end
        default: ;
      endcase
    end
  end

  // Both select vectors come straight from the lock registers.
  always_comb begin
    slave_mux  = '0;
    master_mux = '0;
    for (int s = 0; s < SLAVE_N; s++) begin
      if (st_q[s] == BUSY) begin
        slave_mux[s+1] = own_q[s];
        for (int m = 1; m <= MASTER_N; m++)
          if (own_q[s] == master_num_t'(m))
            master_mux[m] = slave_num_t'(s + 1);
      end
    end
  end

endmodule

// File: tb/tb_cross_bar_mux_ctrl.sv
// Scoreboard bench for cross_bar_mux_ctrl: directed scenarios plus random traffic.
// A per-edge reference model predicts the selects; a monitor compares them.
module tb_cross_bar_mux_ctrl;
  import cross_bar_pkg::*;

  typedef struct packed {
    master_num_t [SLAVE_N:1]  sm;
    slave_num_t  [MASTER_N:1] mm;
  } exp_t;

  logic                         clk = 1'b0;
  logic                         aresetn;
  logic        [MASTER_N-1:0]   req;
  addr_t       [MASTER_N-1:0]   addr;
  logic        [MASTER_N-1:0]   ack;
  master_num_t [SLAVE_N:1]      slave_mux;
  slave_num_t  [MASTER_N:1]     master_mux;
  logic        [SLAVE_N-1:0]    timeout_err;

  int n_chk  = 0;
  int n_fail = 0;

  exp_t q[$];

  int own  [1:SLAVE_N];
  int rr   [1:SLAVE_N];
  int mown [1:MASTER_N];
  int hcnt [MASTER_N];
  int hlen [MASTER_N];
  bit auto_en = 0;
  int rate = 0;

  always #5 clk = ~clk;

  cross_bar_mux_ctrl #(.TIMEOUT_CYC(256)) dut (
    .clk         (clk),
    .aresetn     (aresetn),
    .master_req  (req),
    .master_addr (addr),
    .master_ack  (ack),
    .slave_mux   (slave_mux),
    .master_mux  (master_mux),
    .timeout_err (timeout_err)
  );

  function automatic int dest(addr_t a);
    return int'(a >> (ADDR_W - SLAVE_W)) + 1;
  endfunction

  // Reference: what the selects must be after the coming edge.
  task automatic model_edge();
    int nown [1:SLAVE_N];
    bit taken[1:MASTER_N];
    if (!aresetn) begin
      for (int s = 1; s <= SLAVE_N; s++) begin
        own[s] = 0;
        rr[s]  = MASTER_N;
      end
    end else begin
      for (int m = 1; m <= MASTER_N; m++) taken[m] = 0;
      for (int s = 1; s <= SLAVE_N; s++)
        if (own[s] != 0) taken[own[s]] = 1;
      for (int s = 1; s <= SLAVE_N; s++) begin
        nown[s] = own[s];
        if (own[s] != 0) begin
          if (!req[own[s]-1]) nown[s] = 0;
        end else begin
          for (int k = 1; k <= MASTER_N; k++) begin
            int m;
            m = (rr[s] + k - 1) % MASTER_N + 1;
            if (nown[s] == 0 && req[m-1] && !taken[m]
                && dest(addr[m-1]) == s) begin
              nown[s] = m;
              rr[s]   = m;
            end
          end
        end
      end
      for (int s = 1; s <= SLAVE_N; s++) own[s] = nown[s];
    end
    for (int m = 1; m <= MASTER_N; m++) mown[m] = 0;
    for (int s = 1; s <= SLAVE_N; s++)
      if (own[s] != 0) mown[own[s]] = s;
  endtask

  task automatic push_exp();
    exp_t e;
    e = '0;
    for (int s = 1; s <= SLAVE_N; s++) e.sm[s] = master_num_t'(own[s]);
    for (int m = 1; m <= MASTER_N; m++) e.mm[m] = slave_num_t'(mown[m]);
    q.push_back(e);
  endtask

  // Masters hold req, ack after hlen granted cycles, drop req the cycle after.
  task automatic drive_masters();
    for (int m = 0; m < MASTER_N; m++) begin
      if (!aresetn) begin
        ack[m]  = 1'b0;
        hcnt[m] = 0;
      end else if (req[m] && mown[m+1] != 0) begin
        hcnt[m]++;
        ack[m] = (hcnt[m] == hlen[m]);
        if (hcnt[m] > hlen[m]) begin
          req[m]  = 1'b0;
          hcnt[m] = 0;
        end
      end else if (!req[m] && mown[m+1] == 0
                   && $urandom_range(99) < rate) begin
        req[m]  = 1'b1;
        addr[m] = addr_t'($urandom);
        hlen[m] = $urandom_range(1, 6);
        hcnt[m] = 0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (auto_en) drive_masters();
    model_edge();
    push_exp();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_chk++;
        if ({slave_mux, master_mux} !== e || timeout_err !== '0) begin
          n_fail++;
          $display("FAIL sel: got sm=%h mm=%h to=%b expected sm=%h mm=%h to=0",
                   slave_mux, master_mux, timeout_err, e.sm, e.mm);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int seq[$];
    int v;
    bit rq_done;
    int exp_seq[10] = '{1, 0, 2, 0, 3, 0, 4, 0, 1, 0};

    aresetn = 1'b0;
    req     = '1;
    ack     = '0;
    addr    = '0;
    for (int m = 0; m < MASTER_N; m++) begin
      hcnt[m] = 0;
      hlen[m] = 2;
    end

    // Reset held with every master requesting.
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 0 || i == 19) begin
        chk("rst_slave_mux", slave_mux, 0);
        chk("rst_master_mux", master_mux, 0);
      end
    end
    req = '0;
    aresetn = 1'b1;
    step();

    // Single grant, hold through ack, release.
    addr[0] = 32'ha000_0000;
    req[0]  = 1'b1;
    step();
    chk("grant_sm3", slave_mux[3], 1);
    chk("grant_mm1", master_mux[1], 3);
    step();
    ack[0] = 1'b1;
    step();
    chk("hold_ack_sm3", slave_mux[3], 1);
    ack[0] = 1'b0;
    req[0] = 1'b0;
    step();
    chk("release_sm3", slave_mux[3], 0);
    chk("release_mm1", master_mux[1], 0);
    step();

    // Four masters contend for slave 1; M1 comes back during M4.
    addr    = '0;
    rate    = 0;
    auto_en = 1;
    for (int m = 0; m < MASTER_N; m++) begin
      hlen[m] = 2;
      hcnt[m] = 0;
    end
    req = '1;
    rq_done = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      v = int'(slave_mux[1]);
      if (seq.size() == 0 || v != seq[$]) seq.push_back(v);
      if (own[1] == 4 && !rq_done) begin
        req[0]  = 1'b1;
        addr[0] = '0;
        hlen[0] = 2;
        hcnt[0] = 0;
        rq_done = 1;
      end
    end
    for (int i = 0; i < 10; i++) begin
      if (i < seq.size()) chk($sformatf("rr_seq[%0d]", i), seq[i], exp_seq[i]);
      else chk($sformatf("rr_seq[%0d]", i), 32'hffff_ffff, exp_seq[i]);
    end

    // Three slaves granted on the same edge.
    addr[0] = 32'ha000_0000;
    addr[1] = 32'hd200_0004;
    addr[2] = 32'h0000_0000;
    for (int m = 0; m < 3; m++) begin
      hlen[m] = 3;
      hcnt[m] = 0;
    end
    req = 4'b0111;
    step();
    chk("par_sm3", slave_mux[3], 1);
    chk("par_sm4", slave_mux[4], 2);
    chk("par_sm1", slave_mux[1], 3);
    chk("par_mm", master_mux, {3'd0, 3'd1, 3'd4, 3'd3});
    for (int i = 0; i < 10; i++) step();

    // Reset in the middle of a lock, then re-arbitration.
    addr[1] = 32'h4000_0000;
    hlen[1] = 50;
    hcnt[1] = 0;
    req[1]  = 1'b1;
    step();
    chk("mid_grant_sm2", slave_mux[2], 2);
    step();
    step();
    aresetn = 1'b0;
    step();
    chk("mid_rst_sm", slave_mux, 0);
    chk("mid_rst_mm", master_mux, 0);
    step();
    aresetn = 1'b1;
    step();
    chk("mid_regrant_sm2", slave_mux[2], 2);
    chk("mid_regrant_mm2", master_mux[2], 2);
    hlen[1] = 2;
    for (int i = 0; i < 10; i++) step();

    // Random traffic, then let every lock drain.
    rate = 30;
    for (int i = 0; i < 400; i++) step();
    rate = 0;
    for (int i = 0; i < 40; i++) step();
    chk("drain_sm", slave_mux, 0);
    chk("queue_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
